// File: rtl/felis_exec_pkg.sv
// felis_exec_pkg: shared FSM state, instruction-number type and opcode constants for the exec pipeline
package felis_exec_pkg;
  typedef logic [5:0] inst_num_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WRITEBACK = 2'd2} exec_state_t;
  typedef struct packed {
    inst_num_t   inst_num;
    logic [4:0]  shift5;
    logic [4:0]  dest;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] const16_x;
  } issue_op_t;
  localparam inst_num_t OP_SLL = 6'd0;
  localparam inst_num_t OP_ADD = 6'd8;
  localparam inst_num_t OP_SUB = 6'd10;
  localparam inst_num_t OP_DIV = 6'd12;
  localparam inst_num_t OP_ORI = 6'd23;
endpackage

// File: rtl/exec_issue_unit.sv
// exec_issue_unit: single-op-in-flight issue FSM driving an external exec element, with timeout, cancel and writeback
module exec_issue_unit
  import felis_exec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  issue_inst_num,
  input  logic [4:0]  issue_shift5,
  input  logic [4:0]  issue_dest,
  input  logic [31:0] issue_rs,
  input  logic [31:0] issue_rt,
  input  logic [31:0] issue_const16_x,
  output logic        ee_reset,
  output logic [5:0]  ee_inst_num,
  output logic [4:0]  ee_shift5,
  output logic [31:0] ee_rs,
  output logic [31:0] ee_rt,
  output logic [31:0] ee_const16_x,
  input  logic        ee_completed,
  input  logic [31:0] ee_out,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  input  logic        cancel,
  output logic        busy,
  output logic        err_timeout
);
  exec_state_t state, state_nxt;
  issue_op_t   op_q;
  logic [7:0]  cyc_cnt;
  logic        timeout_hit;
  logic        accept;
  logic        run_live;
  assign timeout_hit = cyc_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign accept      = state == IDLE && issue_valid;
  assign run_live    = state == RUN && !cancel;
  // state register; reset pulls the FSM to IDLE immediately, even mid-op
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next state: in RUN, cancel beats completion, completion beats timeout
  always_comb begin
    state_nxt = (state == IDLE) ? (issue_valid ? RUN : IDLE) :
                (state == RUN)  ? (cancel ? IDLE : ee_completed ? WRITEBACK : timeout_hit ? IDLE : RUN) :
                IDLE;
  end
  // state-decoded outputs; r0 writes are swallowed here
  always_comb begin
    issue_ready = state == IDLE;
    busy        = state != IDLE;
    ee_reset    = state != RUN;
    wb_valid    = state == WRITEBACK && wb_dest != 5'd0;
  end
  // operand latch, cycle counter, result capture and sticky timeout flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_q        <= '0;
      cyc_cnt     <= '0;
      wb_dest     <= '0;
      wb_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= '{issue_inst_num, issue_shift5, issue_dest, issue_rs, issue_rt, issue_const16_x};
        cyc_cnt <= '0;
      end
      if (run_live && ee_completed) begin
        wb_data <= ee_out;
        wb_dest <= op_q.dest;
      end
      if (run_live && !ee_completed && timeout_hit) err_timeout <= 1'b1;
      if (run_live && !ee_completed && !timeout_hit) cyc_cnt <= cyc_cnt + 8'd1;
    end
  assign ee_inst_num  = op_q.inst_num;
  assign ee_shift5    = op_q.shift5;
  assign ee_rs        = op_q.rs;
  assign ee_rt        = op_q.rt;
  assign ee_const16_x = op_q.const16_x;
endmodule

// File: doc/exec_issue_unit.md
EXEC_ISSUE_UNIT -- requirements
Module: exec_issue_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 64, max RUN cycles before abort (2..255).
REQ-002 SHALL have port: clk  in  1  sole clock; all flops rise-edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: issue_valid in 1, issue_ready out 1  decode-side valid/ready handshake.
REQ-005 SHALL have ports: issue_inst_num in 6, issue_shift5 in 5, issue_dest in 5  decoded opcode, shift amount, destination register.
REQ-006 SHALL have ports: issue_rs, issue_rt, issue_const16_x  in  32 each  operands, sign-extended immediate.
REQ-007 SHALL have ports: ee_reset out 1, ee_inst_num out 6, ee_shift5 out 5, ee_rs/ee_rt/ee_const16_x out 32  drive exec element (active-high sync reset clears its completed).
REQ-008 SHALL have ports: ee_completed in 1, ee_out in 32  exec element result.
REQ-009 SHALL have ports: wb_valid out 1, wb_dest out 5, wb_data out 32  register-file write.
REQ-010 SHALL have ports: cancel in 1 (abort current op), busy out 1, err_timeout out 1 (sticky).

Function
REQ-011 SHALL implement FSM states IDLE, RUN, WRITEBACK.
REQ-012 IDLE: issue_ready=1, ee_reset=1; on issue_valid latch all issue_* fields into operand registers, clear cycle counter, go RUN.
REQ-013 RUN: ee_reset=0, issue_ready=0, ee_* driven from latched registers only (stable whole op).
REQ-014 RUN with ee_completed=1: capture ee_out into wb_data, latched dest into wb_dest, go WRITEBACK.
REQ-015 RUN without completion: increment 8-bit cycle counter; when counter == TIMEOUT_CYCLES-1 go IDLE, set err_timeout, no writeback.
REQ-016 WRITEBACK: wb_valid=1 for exactly one cycle unless wb_dest==0 (r0 hardwired, write suppressed); ee_reset=1; next state IDLE.
REQ-017 Latency for single-cycle op: accept edge cycle 0, RUN cycles 1-2, wb_valid high in cycle 3; multi-cycle ops add element latency.
REQ-018 No back-to-back overlap: issue_ready low in RUN and WRITEBACK; max one op in flight.
REQ-019 cancel in RUN: go IDLE next edge, no writeback, err_timeout unchanged; cancel ignored in IDLE/WRITEBACK.
REQ-020 cancel and ee_completed in same RUN cycle: cancel wins, no writeback.
REQ-021 Timeout and ee_completed in same cycle: completion wins, normal writeback, err_timeout unchanged.
REQ-022 busy = 1 in RUN and WRITEBACK, 0 in IDLE.
REQ-023 ee_completed SHALL be ignored outside RUN.
REQ-024 err_timeout clears only on reset.

Reset
REQ-025 reset low SHALL immediately force state IDLE, regardless of current state (incl. mid-RUN).
REQ-026 Reset values: issue_ready=1, busy=0, ee_reset=1, wb_valid=0, wb_dest=0, wb_data=0, err_timeout=0, cycle counter=0, latched operands/ee_* =0.
REQ-027 First accept SHALL be possible in first cycle after reset deassertion.

Structure
REQ-028 Shared package felis_exec_pkg SHALL hold FSM state enum, 6-bit instruction-number type, and opcode constants (ADD=8, DIV=12, etc.).
REQ-029 Exec element and divider SHALL be instantiated outside this block; no sub-module inside — FSM, counter and operand registers are flat.

Verification
REQ-030 ADD(8) rs=5 rt=7 dest=3 with real ALU element -> wb_valid in cycle 3 only, wb_dest=3, wb_data=12, issue_ready back to 1 in cycle 4.
REQ-031 DIV(12) rs=100 rt=7 dest=4, element completes after 10 RUN cycles -> wb_data=14, busy=1 and issue_ready=0 throughout, single wb_valid pulse.
REQ-032 Stub element never completes, TIMEOUT_CYCLES=64 -> IDLE after 64 RUN cycles, err_timeout=1, no wb_valid; next op ADD 1+1 dest=2 -> wb_data=2, err_timeout still 1.
REQ-033 ORI(23) rs=0x12340000 const=0x00FF dest=0 -> no wb_valid, FSM returns to IDLE normally.
REQ-034 DIV issued, cancel pulsed in RUN cycle 3 coincident with stub ee_completed -> IDLE next cycle, no wb_valid, ee_reset=1.
REQ-035 reset driven low mid-RUN between clock edges -> all outputs reach REQ-026 values before next edge; new op accepted after release.
